// File: rtl/cmd_frame_ctrl.sv
// rtl/cmd_frame_ctrl.sv - host command-frame decoder driving register file, ALU and TX FIFO
//
// Purpose:
//   Consumes bytes from the UART receiver and decodes four host commands:
//     0xAA addr data        register write
//     0xBB addr             register read, one response byte
//     0xCC opa opb fun      operand writes to reg 0/1, then ALU op, two response bytes
//     0xDD fun              ALU op on existing operands, two response bytes
//   Response bytes are pushed low byte first into the TX async FIFO.
//
// Build option:
//   CMD_TIMEOUT_EN - adds an inter-byte timeout and the CMD_TIMEOUT output.
//
// Ports:
//   CLK, RST                  reference clock, synchronous active-high reset
//   RX_P_DATA, RX_D_VLD       received byte and its one-cycle strobe
//   RF_ADDR, RF_WR_EN,
//   RF_RD_EN, RF_WR_DATA      register-file address, strobes, write data
//   RF_RD_DATA, RF_RD_VLD     register-file read data and valid strobe
//   ALU_EN, ALU_FUN           ALU start strobe and function
//   CLK_GATE_EN               ALU clock-gate enable (set with ALU_EN, cleared on result)
//   ALU_OUT, ALU_OUT_VLD      ALU result and valid strobe
//   FIFO_WR_DATA, FIFO_WR_INC TX FIFO push data and push strobe (combinational)
//   FIFO_FULL                 TX FIFO full flag
//   BUSY                      high whenever the FSM is not idle
//   CMD_TIMEOUT               one-cycle abort pulse (CMD_TIMEOUT_EN only)

module cmd_frame_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]    RF_ADDR,
  output logic                     RF_WR_EN,
  output logic                     RF_RD_EN,
  output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
  input  logic                     RF_RD_VLD,
  output logic                     ALU_EN,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic                     CLK_GATE_EN,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]    FIFO_WR_DATA,
  output logic                     FIFO_WR_INC,
  input  logic                     FIFO_FULL,
  output logic                     BUSY
`ifdef CMD_TIMEOUT_EN
  ,
  output logic                     CMD_TIMEOUT
`endif
);

  // Elaboration-time configuration guards.
  if (ALU_OUT_WIDTH != 2 * DATA_WIDTH) begin : g_bad_alu_width
    $error("cmd_frame_ctrl: ALU_OUT_WIDTH must equal 2*DATA_WIDTH");
  end
  if (ADDR_WIDTH > DATA_WIDTH || ALU_FUN_WIDTH > DATA_WIDTH || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("cmd_frame_ctrl: ADDR/FUN width exceed DATA_WIDTH or TIMEOUT_CYCLES < 2");
  end

  localparam logic [DATA_WIDTH-1:0] CMD_RF_WR   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RF_RD   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_OPA,
    S_OPB,
    S_FUN,
    S_ALU_WAIT,
    S_PUSH_LO,
    S_PUSH_HI
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] hold_lo;
  logic [DATA_WIDTH-1:0] hold_hi;
  logic                  two_byte;   // response carries a high byte (ALU result)

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt;
  logic             byte_wait;
  logic             tmo_hit;

  // Only states that are waiting on the host for the next byte can time out.
  assign byte_wait = (state == S_WR_ADDR) || (state == S_WR_DATA) ||
                     (state == S_RD_ADDR) || (state == S_OPA)     ||
                     (state == S_OPB)     || (state == S_FUN);

  // A byte arriving on the same edge wins over the abort.
  assign tmo_hit = byte_wait && !RX_D_VLD &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt <= '0;
    end else if (RX_D_VLD || !byte_wait) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`endif

  // Push strobe follows FIFO_FULL combinationally so a free slot is used
  // in the same cycle it appears; the state only advances when it is taken.
  always_comb begin
    FIFO_WR_INC  = 1'b0;
    FIFO_WR_DATA = '0;
    if (state == S_PUSH_LO) begin
      FIFO_WR_INC  = !FIFO_FULL;
      FIFO_WR_DATA = hold_lo;
    end else if (state == S_PUSH_HI) begin
      FIFO_WR_INC  = !FIFO_FULL;
      FIFO_WR_DATA = hold_hi;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      BUSY        <= 1'b0;
      hold_lo     <= '0;
      hold_hi     <= '0;
      two_byte    <= 1'b0;
      RF_ADDR     <= '0;
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      RF_WR_DATA  <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      CMD_TIMEOUT <= 1'b0;
`endif
    end else begin
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      ALU_EN   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      CMD_TIMEOUT <= 1'b0;
      if (tmo_hit) begin
        state       <= S_IDLE;
        BUSY        <= 1'b0;
        CMD_TIMEOUT <= 1'b1;
      end else begin
`else
      begin
`endif
        case (state)
          S_IDLE: begin
            if (RX_D_VLD) begin
              // Unknown command bytes leave the FSM idle.
              if (RX_P_DATA == CMD_RF_WR) begin
                state <= S_WR_ADDR;
                BUSY  <= 1'b1;
              end else if (RX_P_DATA == CMD_RF_RD) begin
                state <= S_RD_ADDR;
                BUSY  <= 1'b1;
              end else if (RX_P_DATA == CMD_ALU_OP) begin
                state <= S_OPA;
                BUSY  <= 1'b1;
              end else if (RX_P_DATA == CMD_ALU_NOP) begin
                state <= S_FUN;
                BUSY  <= 1'b1;
              end
            end
          end

          S_WR_ADDR: begin
            if (RX_D_VLD) begin
              RF_ADDR <= RX_P_DATA[ADDR_WIDTH-1:0];
              state   <= S_WR_DATA;
            end
          end

          S_WR_DATA: begin
            if (RX_D_VLD) begin
              RF_WR_DATA <= RX_P_DATA;
              RF_WR_EN   <= 1'b1;
              state      <= S_IDLE;
              BUSY       <= 1'b0;
            end
          end

          S_RD_ADDR: begin
            if (RX_D_VLD) begin
              RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
              RF_RD_EN <= 1'b1;
              state    <= S_RD_WAIT;
            end
          end

          S_RD_WAIT: begin
            if (RF_RD_VLD) begin
              hold_lo  <= RF_RD_DATA;
              two_byte <= 1'b0;
              state    <= S_PUSH_LO;
            end
          end

          // Operands land in registers 0 and 1, where the ALU reads them.
          S_OPA: begin
            if (RX_D_VLD) begin
              RF_ADDR    <= '0;
              RF_WR_DATA <= RX_P_DATA;
              RF_WR_EN   <= 1'b1;
              state      <= S_OPB;
            end
          end

          S_OPB: begin
            if (RX_D_VLD) begin
              RF_ADDR    <= ADDR_WIDTH'(1);
              RF_WR_DATA <= RX_P_DATA;
              RF_WR_EN   <= 1'b1;
              state      <= S_FUN;
            end
          end

          // Gate enable and start rise together; the gate stays open until the result.
          S_FUN: begin
            if (RX_D_VLD) begin
              ALU_FUN     <= RX_P_DATA[ALU_FUN_WIDTH-1:0];
              CLK_GATE_EN <= 1'b1;
              ALU_EN      <= 1'b1;
              state       <= S_ALU_WAIT;
            end
          end

          S_ALU_WAIT: begin
            if (ALU_OUT_VLD) begin
              hold_lo     <= ALU_OUT[DATA_WIDTH-1:0];
              hold_hi     <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
              two_byte    <= 1'b1;
              CLK_GATE_EN <= 1'b0;
              state       <= S_PUSH_LO;
            end
          end

          S_PUSH_LO: begin
            if (!FIFO_FULL) begin
              if (two_byte) begin
                state <= S_PUSH_HI;
              end else begin
                state <= S_IDLE;
                BUSY  <= 1'b0;
              end
            end
          end

          S_PUSH_HI: begin
            if (!FIFO_FULL) begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end
          end

          default: begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// tb/tb_cmd_frame_ctrl.sv - randomized self-checking bench for cmd_frame_ctrl
`timescale 1ns/1ps

module tb_cmd_frame_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int OW = 16;
  localparam int FW = 4;
`ifdef CMD_TIMEOUT_EN
  localparam int TMO = 64;
`else
  localparam int TMO = 4096;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] RX_P_DATA;
  logic          RX_D_VLD;
  logic [AW-1:0] RF_ADDR;
  logic          RF_WR_EN;
  logic          RF_RD_EN;
  logic [DW-1:0] RF_WR_DATA;
  logic [DW-1:0] RF_RD_DATA;
  logic          RF_RD_VLD;
  logic          ALU_EN;
  logic [FW-1:0] ALU_FUN;
  logic          CLK_GATE_EN;
  logic [OW-1:0] ALU_OUT;
  logic          ALU_OUT_VLD;
  logic [DW-1:0] FIFO_WR_DATA;
  logic          FIFO_WR_INC;
  logic          FIFO_FULL;
  logic          BUSY;
`ifdef CMD_TIMEOUT_EN
  logic          CMD_TIMEOUT;
`endif

  always #5 CLK = ~CLK;

  cmd_frame_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_OUT_WIDTH(OW),
    .ALU_FUN_WIDTH(FW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .RF_WR_DATA(RF_WR_DATA), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .FIFO_WR_DATA(FIFO_WR_DATA), .FIFO_WR_INC(FIFO_WR_INC), .FIFO_FULL(FIFO_FULL),
    .BUSY(BUSY)
`ifdef CMD_TIMEOUT_EN
    , .CMD_TIMEOUT(CMD_TIMEOUT)
`endif
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Environment knobs set by the main sequence.
  logic [7:0]  rd_val = 8'h00;
  logic [15:0] alu_val = 16'h0000;
  int          rd_lat = 1;
  int          alu_lat = 1;
  bit          full_force = 1'b0;
  bit          full_rand = 1'b0;
  int          cyc = 0;
  int          tmo_seen = 0;

  // Expected vs observed transaction streams; wr entries are {addr, data}.
  logic [11:0] exp_wr[$],   obs_wr[$];
  logic [3:0]  exp_rd[$],   obs_rd[$];
  logic [3:0]  exp_alu[$],  obs_alu[$];
  logic [7:0]  exp_push[$], obs_push[$];
  int          push_cyc[$];
  logic [7:0]  frame_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Transaction monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RF_WR_EN) obs_wr.push_back({RF_ADDR, RF_WR_DATA});
    if (RF_RD_EN) obs_rd.push_back(RF_ADDR);
    if (ALU_EN) begin
      obs_alu.push_back(ALU_FUN);
      check("gate_with_alu_en", CLK_GATE_EN, 1);
    end
    if (FIFO_WR_INC) begin
      obs_push.push_back(FIFO_WR_DATA);
      push_cyc.push_back(cyc);
      if (FIFO_FULL) check("push_while_full", FIFO_WR_INC, 0);
    end
`ifdef CMD_TIMEOUT_EN
    if (CMD_TIMEOUT) tmo_seen <= tmo_seen + 1;
`endif
  end

  // Register-file read responder.
  initial begin
    RF_RD_VLD  = 1'b0;
    RF_RD_DATA = 8'h00;
    forever begin
      @(negedge CLK);
      if (RF_RD_EN) begin
        repeat (rd_lat) @(posedge CLK);
        #1 RF_RD_DATA = rd_val; RF_RD_VLD = 1'b1;
        @(posedge CLK);
        #1 RF_RD_VLD = 1'b0; RF_RD_DATA = 8'($urandom);
      end
    end
  end

  // ALU responder; the gate must still be open while the result is presented.
  initial begin
    ALU_OUT_VLD = 1'b0;
    ALU_OUT     = 16'h0000;
    forever begin
      @(negedge CLK);
      if (ALU_EN) begin
        repeat (alu_lat) @(posedge CLK);
        #1 ALU_OUT = alu_val; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        check("gate_until_vld", CLK_GATE_EN, 1);
        @(posedge CLK);
        #1 ALU_OUT_VLD = 1'b0; ALU_OUT = 16'($urandom);
      end
    end
  end

  // TX FIFO full-flag driver.
  initial begin
    FIFO_FULL = 1'b0;
    forever begin
      @(posedge CLK);
      #1 FIFO_FULL = full_force || (full_rand && ($urandom_range(0, 2) == 0));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1 RX_P_DATA = b; RX_D_VLD = 1'b1;
    @(posedge CLK);
    #1 RX_D_VLD = 1'b0; RX_P_DATA = 8'($urandom);
    repeat ($urandom_range(0, 3)) @(posedge CLK);
  endtask

  task automatic set_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    frame_q.delete();
    if (n > 0) frame_q.push_back(b0);
    if (n > 1) frame_q.push_back(b1);
    if (n > 2) frame_q.push_back(b2);
    if (n > 3) frame_q.push_back(b3);
  endtask

  task automatic clear_q();
    exp_wr.delete();  obs_wr.delete();
    exp_rd.delete();  obs_rd.delete();
    exp_alu.delete(); obs_alu.delete();
    exp_push.delete(); obs_push.delete();
    push_cyc.delete();
  endtask

  // Reference model: what a complete frame must produce on each interface.
  task automatic model_frame();
    logic [7:0] b1, b2, b3;
    b1 = (frame_q.size() > 1) ? frame_q[1] : 8'h00;
    b2 = (frame_q.size() > 2) ? frame_q[2] : 8'h00;
    b3 = (frame_q.size() > 3) ? frame_q[3] : 8'h00;
    case (frame_q[0])
      8'hAA: exp_wr.push_back({b1[3:0], b2});
      8'hBB: begin
        exp_rd.push_back(b1[3:0]);
        exp_push.push_back(rd_val);
      end
      8'hCC: begin
        exp_wr.push_back({4'h0, b1});
        exp_wr.push_back({4'h1, b2});
        exp_alu.push_back(b3[3:0]);
        exp_push.push_back(alu_val[7:0]);
        exp_push.push_back(alu_val[15:8]);
      end
      8'hDD: begin
        exp_alu.push_back(b1[3:0]);
        exp_push.push_back(alu_val[7:0]);
        exp_push.push_back(alu_val[15:8]);
      end
      default: ;
    endcase
  endtask

  task automatic start_frame();
    clear_q();
    model_frame();
    foreach (frame_q[i]) send_byte(frame_q[i]);
  endtask

  task automatic finish_frame(input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while (BUSY && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check({tag, " busy_low"}, BUSY, 0);
    repeat (3) @(negedge CLK);
    check({tag, " wr_count"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      check({tag, " wr"}, obs_wr[i], exp_wr[i]);
    check({tag, " rd_count"}, obs_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
      check({tag, " rd_addr"}, obs_rd[i], exp_rd[i]);
    check({tag, " alu_count"}, obs_alu.size(), exp_alu.size());
    for (int i = 0; i < exp_alu.size() && i < obs_alu.size(); i++)
      check({tag, " alu_fun"}, obs_alu[i], exp_alu[i]);
    check({tag, " push_count"}, obs_push.size(), exp_push.size());
    for (int i = 0; i < exp_push.size() && i < obs_push.size(); i++)
      check({tag, " push"}, obs_push[i], exp_push[i]);
    check({tag, " gate_closed"}, CLK_GATE_EN, 0);
  endtask

  initial begin
    logic [7:0] r1, r2, r3, junk;
    int         kind;
    RST = 1'b1; RX_D_VLD = 1'b0; RX_P_DATA = 8'h00;

    // Reset state.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", BUSY, 0);
    check("rst_strobes", {RF_WR_EN, RF_RD_EN, ALU_EN, FIFO_WR_INC}, 0);
    check("rst_gate", CLK_GATE_EN, 0);
    check("rst_data", {RF_ADDR, RF_WR_DATA, ALU_FUN, FIFO_WR_DATA}, 0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // Register write.
    set_frame(3, 8'hAA, 8'h05, 8'hFF, 8'h00);
    start_frame();
    finish_frame("reg_write");

    // Register read, valid two cycles after the read strobe.
    rd_val = 8'h21; rd_lat = 2;
    set_frame(2, 8'hBB, 8'h02, 8'h00, 8'h00);
    start_frame();
    finish_frame("reg_read");

    // ALU with operands, result three cycles after ALU_EN.
    alu_val = 16'h000A; alu_lat = 3;
    set_frame(4, 8'hCC, 8'h0F, 8'h05, 8'h01);
    start_frame();
    finish_frame("alu_operands");

    // Backpressure: FIFO full for 20 cycles, then two back-to-back pushes.
    alu_val = 16'h0102; alu_lat = 1; full_force = 1'b1;
    set_frame(2, 8'hDD, 8'h0B, 8'h00, 8'h00);
    start_frame();
    repeat (20) @(negedge CLK);
    check("bp_no_push_while_full", obs_push.size(), 0);
    check("bp_busy_stalled", BUSY, 1);
    full_force = 1'b0;
    finish_frame("backpressure");
    check("bp_consecutive", (push_cyc.size() == 2) ? (push_cyc[1] - push_cyc[0]) : -1, 1);

    // Unknown command byte in IDLE.
    set_frame(1, 8'h55, 8'h00, 8'h00, 8'h00);
    start_frame();
    finish_frame("unknown_cmd");

    // Reset in the middle of a write frame discards it.
    clear_q();
    send_byte(8'hAA);
    send_byte(8'h05);
    @(negedge CLK);
    check("midframe_busy", BUSY, 1);
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("after_rst_busy", BUSY, 0);
    send_byte(8'h33);
    finish_frame("reset_abort");

`ifdef CMD_TIMEOUT_EN
    // Silence after a command aborts the frame once.
    clear_q();
    tmo_seen = 0;
    send_byte(8'hBB);
    repeat (100) @(negedge CLK);
    check("tmo_pulses", tmo_seen, 1);
    check("tmo_busy", BUSY, 0);
    check("tmo_no_read", obs_rd.size(), 0);
    set_frame(3, 8'hAA, 8'h03, 8'h7E, 8'h00);
    start_frame();
    finish_frame("after_timeout");
`else
    // Without the timeout the FSM waits indefinitely for the next byte.
    clear_q();
    rd_val = 8'h5C; rd_lat = 1;
    set_frame(2, 8'hBB, 8'h07, 8'h00, 8'h00);
    model_frame();
    send_byte(8'hBB);
    repeat (100) @(negedge CLK);
    check("long_wait_busy", BUSY, 1);
    send_byte(8'h07);
    finish_frame("long_wait");
`endif

    // Randomized frames with random FIFO backpressure and responder latency.
    full_rand = 1'b1;
    for (int f = 0; f < 60; f++) begin
      r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      rd_val  = 8'($urandom);
      alu_val = 16'($urandom);
      rd_lat  = $urandom_range(1, 5);
      alu_lat = $urandom_range(1, 5);
      kind = $urandom_range(0, 4);
      case (kind)
        0: set_frame(3, 8'hAA, r1, r2, 8'h00);
        1: set_frame(2, 8'hBB, r1, 8'h00, 8'h00);
        2: set_frame(4, 8'hCC, r1, r2, r3);
        3: set_frame(2, 8'hDD, r1, 8'h00, 8'h00);
        default: begin
          junk = 8'($urandom);
          while (junk inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) junk = 8'($urandom);
          set_frame(1, junk, 8'h00, 8'h00, 8'h00);
        end
      endcase
      start_frame();
      finish_frame("random");
    end
    full_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
